mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from the mem_en cycle until mem_rdata is valid; legal range 1..15.
REQ-002 Parameter STARVE_LIM, default 4: consecutive data grants allowed while a fetch is waiting; legal range 1..15.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  32  fetch address (pc).
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  output  32  fetched instruction word.
REQ-010 d_req  input  1  data request from load/store; payload held stable until d_gnt.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data address (alu_out).
REQ-013 d_wdata  input  32  store data (size-adjusted r2 value).
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle pulse; load data valid or store complete.
REQ-016 d_rdata  output  32  load data; 0 for stores.
REQ-017 mem_en  output  1  single-port RAM access strobe.
REQ-018 mem_we  output  1  RAM write enable; qualified by mem_en.
REQ-019 mem_addr  output  32  RAM address.
REQ-020 mem_wdata  output  32  RAM write data.
REQ-021 mem_rdata  input  32  RAM read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, RESP; at most one transaction in flight.
REQ-024 IDLE: if any request is present, assert exactly one gnt combinationally in the same cycle, latch owner/we/addr/wdata, then go to ISSUE; with no request, stay in IDLE.
REQ-025 Grants occur only in IDLE; requests in other states are ignored and no gnt is asserted.
REQ-026 Priority: d_req wins over if_req, unless streak == STARVE_LIM and if_req = 1, in which case fetch wins.
REQ-027 streak (4-bit): incremented on a data grant made while if_req = 1; cleared on a fetch grant or a data grant made with if_req = 0; saturates at STARVE_LIM.
REQ-028 ISSUE lasts 1 cycle: mem_en = 1, and mem_we/mem_addr/mem_wdata come from the latches; WAIT is entered with the counter = MEM_LAT.
REQ-029 WAIT lasts exactly MEM_LAT cycles with mem_en = 0; on the last WAIT cycle, mem_rdata is captured (or 0 if a store), and the next state is RESP.
REQ-030 RESP lasts 1 cycle: owner's rvalid = 1 and rdata = captured value; the other requester's rvalid = 0; the next state is IDLE.
REQ-031 Latency: gnt in cycle T, mem_en in T+1, rvalid in T+2+MEM_LAT, next grant possible in T+3+MEM_LAT.
REQ-032 if_rdata/d_rdata hold their last value outside rvalid cycles; mem_we/mem_addr/mem_wdata = 0 whenever mem_en = 0.
REQ-033 Requester deasserting req after gnt has no effect on the in-flight transaction.
REQ-034 if_rvalid and d_rvalid are never high together; if_gnt and d_gnt are never high together.

Reset
REQ-035 When reset = 1 at a rising edge: state goes to IDLE, streak = 0, latches and captured data = 0.
REQ-036 During a reset cycle, all outputs are 0; gnt is suppressed while reset = 1.
REQ-037 Reset mid-transaction abandons it: no rvalid is produced for it, and mem_en does not reassert for it.

Verification
REQ-038 MEM_LAT = 1; if_req with if_addr = 0x00000004 at T, RAM returns 0x00500093 -> if_gnt at T, mem_en with mem_addr = 0x4 at T+1, if_rvalid with if_rdata = 0x00500093 at T+3, busy low at T+4.
REQ-039 MEM_LAT = 1; d_req, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF -> mem_en = mem_we = 1 with mem_wdata = 0xDEADBEEF at T+1, d_rvalid with d_rdata = 0 at T+3, if_rvalid stays 0.
REQ-040 if_req and d_req both held high continuously, STARVE_LIM = 4 -> grant order D, D, D, D, F, D, D, D, D, F; no simultaneous gnts.
REQ-041 MEM_LAT = 3; d load of address 0x20 -> mem_en one cycle, three WAIT cycles, d_rvalid at T+5 carrying the value of mem_rdata from T+4.
REQ-042 reset asserted in the WAIT cycle of a load -> next cycle is IDLE with all outputs 0, no d_rvalid, and a fresh if_req is granted in the first cycle after reset is released.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data ports, one transaction in flight.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, streak_q, streak_d;
  logic        own_d_q, own_d_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        pick_f, pick_d;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    own_d_d    = own_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_f     = 1'b0;
    pick_d     = 1'b0;
    if (state_q == IDLE) begin
      // fetch only overtakes data once the data streak has reached its limit
      pick_f = if_req & (~d_req | (streak_q == LIM));
      pick_d = d_req & ~pick_f;
      if (pick_f | pick_d) begin
        state_d = ISSUE;
        own_d_d = pick_d;
        we_d    = pick_d & d_we;
        addr_d  = pick_d ? d_addr : if_addr;
        wdata_d = pick_d ? d_wdata : 32'd0;
      end
      if (pick_f) streak_d = 4'd0;
      else if (pick_d) streak_d = ~if_req ? 4'd0 : (streak_q == LIM) ? LIM : streak_q + 4'd1;
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
      cnt_d   = LAT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = RESP;
        if (own_d_q) d_rdata_d = we_q ? 32'd0 : mem_rdata;
        else if_rdata_d = mem_rdata;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      own_d_q    <= own_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  // every output is forced low while reset is asserted
  assign if_gnt    = pick_f & ~reset;
  assign d_gnt     = pick_d & ~reset;
  assign mem_en    = (state_q == ISSUE) & ~reset;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : 32'd0;
  assign mem_wdata = mem_en ? wdata_q : 32'd0;
  assign if_rvalid = (state_q == RESP) & ~own_d_q & ~reset;
  assign d_rvalid  = (state_q == RESP) & own_d_q & ~reset;
  assign if_rdata  = reset ? 32'd0 : if_rdata_q;
  assign d_rdata   = reset ? 32'd0 : d_rdata_q;
  assign busy      = (state_q != IDLE) & ~reset;
endmodule
